// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between NREQ requesters.
// The granted operation is shifted and registered onto a single valid/ready output.
module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [5*NREQ-1:0] req_s,
  input  logic [NREQ-1:0]   req_right,
  input  logic [NREQ-1:0]   req_arith,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [IDW-1:0]    out_id,
  output logic [CNTW-1:0]   served_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW:0]   idx;
  logic           found;
  logic           can_accept;
  logic           accept;
  logic [31:0]    sel_data;
  logic [4:0]     sel_s;
  logic           sel_right;
  logic           sel_arith;
  logic [31:0]    shifted;

  assign can_accept = (state == IDLE) | out_ready;
  assign accept     = found & can_accept;

  // Search starts at rr_ptr and wraps; idx carries one spare bit so the wrap is a subtract.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (clrn && accept)
      req_ready[winner] = 1'b1;
  end

  always_comb begin
    sel_data  = '0;
    sel_s     = '0;
    sel_right = 1'b0;
    sel_arith = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        sel_data  = req_data[32*i +: 32];
        sel_s     = req_s[5*i +: 5];
        sel_right = req_right[i];
        sel_arith = req_arith[i];
      end
    end
  end

  always_comb begin
    if (!sel_right)
      shifted = sel_data << sel_s;
    else if (sel_arith)
      shifted = 32'($signed(sel_data) >>> sel_s);
    else
      shifted = sel_data >> sel_s;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= '0;
      served_cnt <= '0;
      rr_ptr     <= '0;
    end else begin
      if (accept) begin
        out_result <= shifted;
        out_id     <= winner;
        served_cnt <= served_cnt + CNTW'(1);
        rr_ptr     <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready && !accept) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of grants, shifts and counters.
module tb_shift_arbiter;

  logic         clk = 1'b0;
  logic         clrn;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [19:0]  req_s;
  logic [3:0]   req_right;
  logic [3:0]   req_arith;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_result;
  logic [1:0]   out_id;
  logic [15:0]  served_cnt;

  int nt = 0;
  int nf = 0;

  // model state
  int          m_ptr;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] m_res;
  int          m_id;

  shift_arbiter #(.NREQ(4), .CNTW(16)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_data(req_data),
    .req_s(req_s), .req_right(req_right), .req_arith(req_arith),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_id(out_id), .served_cnt(served_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                            input bit r, input bit a);
    logic [31:0] ones;
    logic [31:0] fill;
    ones = 32'hffffffff;
    if (!r) return d << s;
    fill = (a && d[31]) ? ~(ones >> s) : 32'h0;
    return (d >> s) | fill;
  endfunction

  task automatic set_op(input int i, input logic [31:0] d, input int s,
                        input bit r, input bit a);
    req_data[32*i +: 32] = d;
    req_s[5*i +: 5]      = 5'(s);
    req_right[i]         = r;
    req_arith[i]         = a;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_valid = 0; m_res = '0; m_id = 0;
  endtask

  // Called just after a negedge with inputs set; returns on the next negedge.
  task automatic cycle(input string tag, output logic [3:0] g);
    int w;
    bit can;
    logic [3:0]  exp_g;
    logic [31:0] exp_res;
    #1;
    can = !m_valid || out_ready;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    exp_g = (can && w >= 0) ? 4'(1 << w) : 4'b0;
    exp_res = '0;
    if (exp_g != 0)
      exp_res = ref_shift(req_data[32*w +: 32], int'(req_s[5*w +: 5]), req_right[w], req_arith[w]);
    nt++;
    if (req_ready !== exp_g) begin
      nf++; $display("FAIL %s grant: got %b expected %b", tag, req_ready, exp_g);
    end
    @(posedge clk); #1;
    if (exp_g != 0) begin
      m_valid = 1; m_res = exp_res; m_id = w; m_ptr = (w + 1) % 4; m_cnt = (m_cnt + 1) % 65536;
    end else if (out_ready) begin
      m_valid = 0;
    end
    nt++;
    if (out_valid !== m_valid) begin
      nf++; $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
    end
    nt++;
    if (served_cnt !== 16'(m_cnt)) begin
      nf++; $display("FAIL %s served_cnt: got %0d expected %0d", tag, served_cnt, m_cnt);
    end
    if (m_valid) begin
      nt++;
      if (out_result !== m_res || out_id !== 2'(m_id)) begin
        nf++; $display("FAIL %s result: got %h id %0d expected %h id %0d",
                       tag, out_result, out_id, m_res, m_id);
      end
    end
    g = exp_g;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 1'b0;
    req_valid = '0; req_data = '0; req_s = '0; req_right = '0; req_arith = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clrn = 1'b0;
    req_valid = 4'hf; req_data = '0; req_s = '0; req_right = '0; req_arith = '0;
    out_ready = 1'b1;
    model_reset();
    #1;
    nt++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_result !== 32'h0 ||
        out_id !== 2'd0 || served_cnt !== 16'd0) begin
      nf++; $display("FAIL reset_state: got rdy=%b v=%b res=%h id=%0d cnt=%0d expected all zero",
                     req_ready, out_valid, out_result, out_id, served_cnt);
    end
    @(negedge clk);
    req_valid = '0;
    clrn = 1'b1;
  endtask

  task automatic test_shift();
    logic [3:0]  g;
    logic [31:0] exp_tab [4];
    bit          r_tab [4];
    bit          a_tab [4];
    int          s_tab [4];
    exp_tab = '{32'h00ff0000, 32'hffff0000, 32'hff0000ff, 32'h0000ff00};
    r_tab   = '{1, 1, 0, 0};
    a_tab   = '{0, 1, 0, 1};
    s_tab   = '{8, 8, 0, 8};
    apply_reset();
    out_ready = 1'b1;
    set_op(0, 32'hff0000ff, 8, 0, 0);
    req_valid = 4'b0001;
    cycle("shift_first", g);
    nt++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000ff00 || out_id !== 2'd0 || served_cnt !== 16'd1) begin
      nf++; $display("FAIL shift_first_lit: got v=%b res=%h id=%0d cnt=%0d expected 1 0000ff00 0 1",
                     out_valid, out_result, out_id, served_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      set_op(0, 32'hff0000ff, s_tab[i], r_tab[i], a_tab[i]);
      cycle("shift_tab", g);
      nt++;
      if (out_result !== exp_tab[i]) begin
        nf++; $display("FAIL shift_tab%0d: got %h expected %h", i, out_result, exp_tab[i]);
      end
    end
    req_valid = '0;
    cycle("shift_drain", g);
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] gexp [4];
    gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 32'h80000001 + 32'(i), i + 1, 1, 1);
    req_valid = 4'hf;
    for (int i = 0; i < 8; i++) begin
      #1;
      nt++;
      if (req_ready !== gexp[i % 4]) begin
        nf++; $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, gexp[i % 4]);
      end
      cycle("rr", g);
      nt++;
      if (out_id !== 2'(i % 4)) begin
        nf++; $display("FAIL rr_id%0d: got %0d expected %0d", i, out_id, i % 4);
      end
    end
    nt++;
    if (served_cnt !== 16'd8) begin
      nf++; $display("FAIL rr_count: got %0d expected 8", served_cnt);
    end
    req_valid = '0;
    cycle("rr_drain", g);
  endtask

  task automatic test_backpressure();
    logic [3:0]  g;
    logic [31:0] held;
    apply_reset();
    out_ready = 1'b1;
    set_op(0, 32'h12345678, 4, 0, 0);
    req_valid = 4'b0001;
    cycle("bp_load", g);
    req_valid = 4'b0100;
    set_op(2, 32'h87654321, 12, 1, 1);
    out_ready = 1'b0;
    held = out_result;
    for (int i = 0; i < 3; i++) begin
      #1;
      nt++;
      if (req_ready !== 4'b0000) begin
        nf++; $display("FAIL bp_stall_rdy%0d: got %b expected 0000", i, req_ready);
      end
      cycle("bp_stall", g);
      nt++;
      if (out_result !== held || out_id !== 2'd0) begin
        nf++; $display("FAIL bp_stable%0d: got %h id %0d expected %h id 0", i, out_result, out_id, held);
      end
    end
    out_ready = 1'b1;
    #1;
    nt++;
    if (req_ready !== 4'b0100) begin
      nf++; $display("FAIL bp_release_rdy: got %b expected 0100", req_ready);
    end
    cycle("bp_release", g);
    nt++;
    if (out_result !== 32'hfff87654 || out_id !== 2'd2) begin
      nf++; $display("FAIL bp_new: got %h id %0d expected fff87654 id 2", out_result, out_id);
    end
    req_valid = '0;
    cycle("bp_drain", g);
  endtask

  task automatic test_sparse();
    logic [3:0] g;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 32'hcafe0000 | 32'(i), i, 0, 0);
    req_valid = 4'b1000;
    cycle("sparse3", g);
    nt++;
    if (out_id !== 2'd3) begin
      nf++; $display("FAIL sparse3_id: got %0d expected 3", out_id);
    end
    req_valid = 4'b0011;
    #1;
    nt++;
    if (req_ready !== 4'b0001) begin
      nf++; $display("FAIL sparse_wrap: got %b expected 0001", req_ready);
    end
    cycle("sparse_wrap", g);
    req_valid = 4'b0010;
    cycle("sparse1", g);
    nt++;
    if (out_id !== 2'd1) begin
      nf++; $display("FAIL sparse1_id: got %0d expected 1", out_id);
    end
    req_valid = '0;
    cycle("sparse_idle", g);
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 32'h0f0f0f0f, 4, 1, 0);
    req_valid = 4'b1100;
    cycle("ar_load", g);
    #2;
    clrn = 1'b0;
    #1;
    nt++;
    if (out_valid !== 1'b0 || served_cnt !== 16'd0 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
      nf++; $display("FAIL async_reset: got v=%b cnt=%0d id=%0d rdy=%b expected 0 0 0 0000",
                     out_valid, served_cnt, out_id, req_ready);
    end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    out_ready = 1'b1;
    req_valid = 4'b0110;
    #1;
    nt++;
    if (req_ready !== 4'b0010) begin
      nf++; $display("FAIL async_first_grant: got %b expected 0010", req_ready);
    end
    cycle("ar_after", g);
    req_valid = '0;
    cycle("ar_drain", g);
  endtask

  task automatic test_random();
    logic [3:0] g;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          set_op(i, $urandom, int'($urandom % 32), 1'($urandom), 1'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom % 4) != 0;
      cycle("random", g);
      req_valid = req_valid & ~g;
    end
    req_valid = '0;
    out_ready = 1'b1;
    cycle("random_drain", g);
  endtask

  initial begin
    clrn = 1'b0;
    req_valid = '0; req_data = '0; req_s = '0; req_right = '0; req_arith = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_shift();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
